// File: rtl/csr_arb_pkg.sv
// Shared types and sizing helpers for the CSR access arbiter.
package csr_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SETTLE,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } csr_arb_state_e;

  function automatic int unsigned settle_cnt_w(input int unsigned settle_max);
    return $clog2(settle_max + 1);
  endfunction

endpackage

// File: rtl/csr_rr_pick.sv
// Combinational round-robin picker: search starts one past the last winner.
module csr_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    cand  = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_winner) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    grant = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/csr_arb.sv
// Arbitrates NUM_REQ requesters onto the single CSR access path and sequences
// each accepted request into address-select, settle, write/read and response.
module csr_arb
  import csr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned SETTLE_MAX = 7
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic                      arb_csr_addr_valid,
  output logic [ADDR_W-1:0]         arb_csr_addr,
  output logic                      arb_csr_data_valid,
  output logic [DATA_W-1:0]         arb_csr_data,
  input  logic [ADDR_W-1:0]         csr_addr,
  input  logic [DATA_W-1:0]         csr_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = settle_cnt_w(SETTLE_MAX);

  csr_arb_state_e state_q, state_d;

  logic [IDX_W-1:0]   winner_q;
  logic [IDX_W-1:0]   last_q;
  logic               write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic [DATA_W-1:0]  rdata_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               addr_match;
  logic               settle_expired;

  csr_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req         (req_valid),
    .last_winner (last_q),
    .grant       (grant),
    .idx         (pick_idx),
    .any         (pick_any)
  );

  assign sel_write      = req_write[pick_idx];
  assign sel_addr       = req_addr[pick_idx*ADDR_W +: ADDR_W];
  assign sel_wdata      = req_wdata[pick_idx*DATA_W +: DATA_W];
  assign addr_match     = (csr_addr == addr_q);
  assign settle_expired = (cnt_q == CNT_W'(SETTLE_MAX));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_any) state_d = ST_ADDR;
      ST_ADDR:   state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (addr_match) begin
          state_d = write_q ? ST_WRITE : ST_READ;
        end else if (settle_expired) begin
          state_d = ST_RESP;
        end
      end
      ST_WRITE:  state_d = ST_RESP;
      ST_READ:   state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // wdata_q only moves on a write accept so arb_csr_data keeps the last written value
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      winner_q <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            winner_q <= pick_idx;
            write_q  <= sel_write;
            addr_q   <= sel_addr;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            if (sel_write) wdata_q <= sel_wdata;
          end
        end
        ST_ADDR:   cnt_q <= '0;
        ST_SETTLE: begin
          if (!addr_match) begin
            if (settle_expired) err_q <= 1'b1;
            else                cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_READ:   rdata_q <= csr_data;
        ST_RESP:   last_q  <= winner_q;
        default:   ;
      endcase
    end
  end

  always_comb begin
    req_ready          = '0;
    rsp_valid          = '0;
    rsp_err            = 1'b0;
    rsp_rdata          = '0;
    arb_csr_addr_valid = 1'b0;
    arb_csr_data_valid = 1'b0;
    if (!sys_rst) begin
      case (state_q)
        ST_IDLE:  req_ready          = grant;
        ST_ADDR:  arb_csr_addr_valid = 1'b1;
        ST_WRITE: arb_csr_data_valid = 1'b1;
        ST_RESP: begin
          rsp_valid = NUM_REQ'(1) << winner_q;
          rsp_err   = err_q;
          rsp_rdata = rdata_q;
        end
        default:  ;
      endcase
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign arb_csr_addr = addr_q;
  assign arb_csr_data = wdata_q;

endmodule

// File: tb/tb_csr_arb.sv
// Self-checking bench for csr_arb with a small CSR model and a response scoreboard.
module tb_csr_arb;

  localparam int NR = 2;
  localparam int AW = 3;
  localparam int DW = 32;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [NR-1:0]     req_valid, req_ready, req_write, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic              rsp_err, busy, arb_csr_addr_valid, arb_csr_data_valid;
  logic [DW-1:0]     rsp_rdata, arb_csr_data, csr_data;
  logic [AW-1:0]     arb_csr_addr;
  logic [AW-1:0]     csr_addr = '0;

  csr_arb #(
    .NUM_REQ    (NR),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .SETTLE_MAX (7)
  ) dut (
    .sys_clk            (sys_clk),
    .sys_rst            (sys_rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_write          (req_write),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_err            (rsp_err),
    .rsp_rdata          (rsp_rdata),
    .busy               (busy),
    .arb_csr_addr_valid (arb_csr_addr_valid),
    .arb_csr_addr       (arb_csr_addr),
    .arb_csr_data_valid (arb_csr_data_valid),
    .arb_csr_data       (arb_csr_data),
    .csr_addr           (csr_addr),
    .csr_data           (csr_data)
  );

  always #5 sys_clk = ~sys_clk;

  // CSR model: selects the pulsed address one cycle later unless stuck
  logic [DW-1:0] regs [8];
  bit            loaded = 1'b0;
  logic          stuck = 1'b0;
  always @(posedge sys_clk) begin
    if (!loaded) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      regs[3] <= 32'hDEADBEEF;
      regs[5] <= 32'h12345678;
      loaded  <= 1'b1;
    end else begin
      if (arb_csr_addr_valid && !stuck) csr_addr <= arb_csr_addr;
      if (arb_csr_data_valid) regs[csr_addr] <= arb_csr_data;
    end
  end
  assign csr_data = regs[csr_addr];

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0]  oh;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;
  rsp_t sbq[$];

  int          addr_pulses = 0;
  int          data_pulses = 0;
  int          rsp_count   = 0;
  logic [31:0] last_data;
  logic [2:0]  last_addr;

  always @(negedge sys_clk) begin
    rsp_t e;
    if (!sys_rst) begin
      if (arb_csr_addr_valid) begin addr_pulses++; last_addr = arb_csr_addr; end
      if (arb_csr_data_valid) begin data_pulses++; last_data = arb_csr_data; end
      if (rsp_valid != '0) begin
        rsp_count++;
        if (sbq.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = sbq.pop_front();
          check("rsp_valid", 64'(rsp_valid), 64'(e.oh));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        end
      end else begin
        check("rsp_idle_zero", {31'd0, rsp_err, rsp_rdata}, 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic sample();
    @(negedge sys_clk); #1;
  endtask

  typedef struct {
    int unsigned rq;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        stk;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    int a0, d0, n0, acc;
    bit got;
    oh = 2'b01 << v.rq;
    sbq.push_back('{oh: oh, err: v.err, rdata: v.rdata});
    stuck = v.stk;
    a0 = addr_pulses; d0 = data_pulses; n0 = rsp_count;
    step();
    req_valid[v.rq] = 1'b1;
    req_write[v.rq] = v.wr;
    req_addr[v.rq*AW +: AW]  = v.addr;
    req_wdata[v.rq*DW +: DW] = v.wdata;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      sample();
      if (req_ready[v.rq]) got = 1'b1;
    end
    check("accept_seen", 64'(got), 64'd1);
    check("ready_onehot", 64'(req_ready), 64'(oh));
    acc = cyc;
    step();
    req_valid[v.rq] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      sample();
      if (rsp_count != n0) got = 1'b1;
    end
    check("rsp_seen", 64'(got), 64'd1);
    check("latency", 64'(cyc - acc), 64'(v.lat));
    check("addr_pulses", 64'(addr_pulses - a0), 64'd1);
    check("addr_value", 64'(last_addr), 64'(v.addr));
    check("data_pulses", 64'(data_pulses - d0), 64'(v.wr && !v.err));
    if (v.wr && !v.err) check("data_value", 64'(last_data), 64'(v.wdata));
    stuck = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int a0, d0, n0, grants, last_acc;
    bit got, saw_ready;
    vecs[0] = '{rq: 0, wr: 0, addr: 3, wdata: 0,      stk: 0, err: 0, rdata: 32'hDEADBEEF, lat: 4};
    vecs[1] = '{rq: 1, wr: 1, addr: 2, wdata: 32'hA,  stk: 0, err: 0, rdata: 0,            lat: 4};
    vecs[2] = '{rq: 0, wr: 0, addr: 2, wdata: 0,      stk: 0, err: 0, rdata: 32'hA,        lat: 4};
    vecs[3] = '{rq: 1, wr: 0, addr: 5, wdata: 0,      stk: 0, err: 0, rdata: 32'h12345678, lat: 4};
    vecs[4] = '{rq: 0, wr: 1, addr: 7, wdata: '1,     stk: 0, err: 0, rdata: 0,            lat: 4};
    vecs[5] = '{rq: 1, wr: 0, addr: 7, wdata: 0,      stk: 0, err: 0, rdata: 32'hFFFFFFFF, lat: 4};
    vecs[6] = '{rq: 1, wr: 0, addr: 4, wdata: 0,      stk: 1, err: 1, rdata: 0,            lat: 10};
    vecs[7] = '{rq: 0, wr: 1, addr: 1, wdata: 32'h5,  stk: 1, err: 1, rdata: 0,            lat: 10};

    sys_rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) step();
    sys_rst = 1'b0;
    sample();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp", 64'(rsp_valid), 64'd0);
    check("rst_pulses", {62'd0, arb_csr_addr_valid, arb_csr_data_valid}, 64'd0);
    check("rst_csr_outs", {29'd0, arb_csr_addr, arb_csr_data}, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while a write sits in SETTLE (csr never selects): abort silently
    stuck = 1'b1;
    a0 = addr_pulses; d0 = data_pulses; n0 = rsp_count;
    step();
    req_valid[1] = 1'b1; req_write[1] = 1'b1;
    req_addr[AW +: AW] = 3'd6; req_wdata[DW +: DW] = 32'h55;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      sample();
      if (req_ready[1]) got = 1'b1;
    end
    check("rst_mid_accept", 64'(got), 64'd1);
    step();
    req_valid[1] = 1'b0;
    step();
    sample();
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    sample();
    check("rst_mid_busy_after", 64'(busy), 64'd0);
    repeat (12) step();
    check("rst_mid_no_data", 64'(data_pulses - d0), 64'd0);
    check("rst_mid_no_rsp", 64'(rsp_count - n0), 64'd0);
    check("rst_mid_addr_pulses", 64'(addr_pulses - a0), 64'd1);
    stuck = 1'b0;

    // Both requesters hold valid: grants alternate from requester 0 at a 5-cycle period
    n0 = rsp_count;
    for (int i = 0; i < 6; i++)
      sbq.push_back('{oh: (i % 2 == 0) ? 2'b01 : 2'b10, err: 1'b0,
                      rdata: (i % 2 == 0) ? 32'hDEADBEEF : 32'h12345678});
    step();
    req_write = '0;
    req_addr  = {3'd5, 3'd3};
    req_valid = 2'b11;
    grants = 0; last_acc = 0;
    for (int i = 0; i < 80 && grants < 6; i++) begin
      sample();
      if (req_ready != '0) begin
        check("rr_grant", 64'(req_ready), (grants % 2 == 0) ? 64'd1 : 64'd2);
        if (grants > 0) check("rr_period", 64'(cyc - last_acc), 64'd5);
        last_acc = cyc;
        grants++;
        if (grants == 6) begin
          step();
          req_valid = '0;
        end
      end
    end
    check("rr_grants", 64'(grants), 64'd6);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      sample();
      if (rsp_count - n0 == 6) got = 1'b1;
    end
    check("rr_rsps", 64'(rsp_count - n0), 64'd6);

    // Requester 0 pulses valid for one cycle while busy and is never served
    sbq.push_back('{oh: 2'b10, err: 1'b0, rdata: 32'h12345678});
    a0 = addr_pulses; d0 = data_pulses; n0 = rsp_count;
    step();
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[AW +: AW] = 3'd5;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      sample();
      if (req_ready[1]) got = 1'b1;
    end
    check("drop_accept1", 64'(got), 64'd1);
    step();
    req_valid[1] = 1'b0;
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[0 +: AW] = 3'd0; req_wdata[0 +: DW] = 32'h99;
    sample();
    saw_ready = (req_ready != '0);
    step();
    req_valid[0] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      sample();
      if (req_ready != '0) saw_ready = 1'b1;
    end
    check("drop_no_ready", 64'(saw_ready), 64'd0);
    check("drop_addr_pulses", 64'(addr_pulses - a0), 64'd1);
    check("drop_data_pulses", 64'(data_pulses - d0), 64'd0);
    check("drop_rsps", 64'(rsp_count - n0), 64'd1);
    check("drop_reg0", 64'(regs[0]), 64'd0);

    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule
